// File: rtl/ifetch_miss_queue_pkg.sv
// Shared types for the instruction-fetch miss queue.
package ifetch_miss_queue_pkg;

    localparam int unsigned THREADS_PER_CORE       = 4;
    localparam int unsigned CACHE_LINE_INDEX_WIDTH = 26;

    typedef logic [CACHE_LINE_INDEX_WIDTH-1:0]    cache_line_index_t;
    typedef logic [$clog2(THREADS_PER_CORE)-1:0]  local_thread_idx_t;
    typedef logic [$clog2(THREADS_PER_CORE)-1:0]  imq_entry_idx_t;

    typedef enum logic [1:0] {
        IMQ_EMPTY      = 2'd0,
        IMQ_WAIT_ISSUE = 2'd1,
        IMQ_WAIT_RESP  = 2'd2
    } imq_entry_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at the priority pointer,
// pointer moves past the granted requester when update_en is high.
module rr_arbiter #(
    parameter int unsigned NUM_REQUESTERS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQUESTERS-1:0] request,
    input  logic                      update_en,
    output logic [NUM_REQUESTERS-1:0] grant_oh
);

    localparam int unsigned IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

    logic [IDX_W-1:0] prio_q;
    logic [IDX_W-1:0] prio_d;
    logic [IDX_W-1:0] scan_pos;
    logic [IDX_W-1:0] grant_idx;
    logic             found;

    // Circular scan from the priority pointer; pointer advance on update
    always_comb begin
        grant_oh  = '0;
        found     = 1'b0;
        grant_idx = '0;
        scan_pos  = '0;
        for (int k = 0; k < int'(NUM_REQUESTERS); k++) begin
            scan_pos = IDX_W'((32'(prio_q) + 32'(k)) % NUM_REQUESTERS);
            if (!found && request[scan_pos]) begin
                found              = 1'b1;
                grant_idx          = scan_pos;
                grant_oh[scan_pos] = 1'b1;
            end
        end
        prio_d = prio_q;
        if (update_en && found) begin
            prio_d = (32'(grant_idx) == NUM_REQUESTERS - 1) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    // Priority pointer register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prio_q <= '0;
        else        prio_q <= prio_d;
    end

endmodule

// File: rtl/ifetch_miss_queue.sv
// Per-core I-cache miss queue: merges same-line misses across threads,
// round-robin issues pending lines to L2, wakes waiters on fill.
module ifetch_miss_queue
    import ifetch_miss_queue_pkg::*;
#(
    parameter int unsigned THREADS = THREADS_PER_CORE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ifd_cache_miss,
    input  cache_line_index_t          ifd_cache_miss_paddr,
    input  local_thread_idx_t          ifd_cache_miss_thread_idx,
    output logic                       imq_request_valid,
    output cache_line_index_t          imq_request_paddr,
    output logic [$clog2(THREADS)-1:0] imq_request_idx,
    input  logic                       imq_request_ack,
    input  logic                       l2_response_valid,
    input  logic [$clog2(THREADS)-1:0] l2_response_idx,
    output logic [THREADS-1:0]         imq_wake_bitmap
);

    localparam int unsigned IDX_W = $clog2(THREADS);

    imq_entry_state_t  state_q   [THREADS];
    imq_entry_state_t  state_d   [THREADS];
    cache_line_index_t paddr_q   [THREADS];
    cache_line_index_t paddr_d   [THREADS];
    logic [THREADS-1:0] waiters_q [THREADS];
    logic [THREADS-1:0] waiters_d [THREADS];
    logic [THREADS-1:0] wake_q, wake_d;
    logic               lock_q, lock_d;
    logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;

    logic [THREADS-1:0] arb_req, grant_oh, hit_vec, waiter_union, thread_oh;
    logic [IDX_W-1:0]   grant_idx, hit_idx, tid;
    logic               any_hit;
    logic               alloc_conflict, merge_conflict, resp_conflict;

    assign tid = IDX_W'(ifd_cache_miss_thread_idx);

    // Address match, arbiter request vector (pinned to the locked entry) and grant decode
    always_comb begin
        hit_vec      = '0;
        waiter_union = '0;
        arb_req      = '0;
        any_hit      = 1'b0;
        hit_idx      = '0;
        grant_idx    = '0;
        thread_oh    = '0;
        thread_oh[tid] = 1'b1;
        for (int i = 0; i < int'(THREADS); i++) begin
            hit_vec[i] = ifd_cache_miss && (state_q[i] != IMQ_EMPTY)
                         && !(l2_response_valid && (l2_response_idx == IDX_W'(i)))
                         && (paddr_q[i] == ifd_cache_miss_paddr);
            arb_req[i] = lock_q ? (lock_idx_q == IDX_W'(i)) : (state_q[i] == IMQ_WAIT_ISSUE);
            waiter_union = waiter_union | waiters_q[i];
        end
        for (int i = int'(THREADS) - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                any_hit = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (grant_oh[i]) grant_idx = IDX_W'(i);
        end
    end

    rr_arbiter #(
        .NUM_REQUESTERS (THREADS)
    ) u_rr_arbiter (
        .clk       (clk),
        .reset     (reset),
        .request   (arb_req),
        .update_en (imq_request_ack),
        .grant_oh  (grant_oh)
    );

    assign imq_request_valid = |grant_oh;
    assign imq_request_idx   = grant_idx;
    assign imq_request_paddr = imq_request_valid ? paddr_q[grant_idx] : '0;
    assign imq_wake_bitmap   = wake_q;

    // Entry next-state: ack, then response free, then miss merge/allocate
    always_comb begin
        for (int i = 0; i < int'(THREADS); i++) begin
            state_d[i]   = state_q[i];
            paddr_d[i]   = paddr_q[i];
            waiters_d[i] = waiters_q[i];
        end
        wake_d     = '0;
        lock_d     = imq_request_valid && !imq_request_ack;
        lock_idx_d = grant_idx;
        if (imq_request_valid && imq_request_ack) state_d[grant_idx] = IMQ_WAIT_RESP;
        if (l2_response_valid) begin
            wake_d                     = waiters_q[l2_response_idx];
            state_d[l2_response_idx]   = IMQ_EMPTY;
            waiters_d[l2_response_idx] = '0;
        end
        if (ifd_cache_miss) begin
            if (any_hit) begin
                waiters_d[hit_idx] = waiters_q[hit_idx] | thread_oh;
            end else begin
                state_d[tid]   = IMQ_WAIT_ISSUE;
                waiters_d[tid] = thread_oh;
                paddr_d[tid]   = ifd_cache_miss_paddr;
            end
        end
    end

    // Entry storage, wake and grant-lock registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(THREADS); i++) begin
                state_q[i]   <= IMQ_EMPTY;
                paddr_q[i]   <= '0;
                waiters_q[i] <= '0;
            end
            wake_q     <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            for (int i = 0; i < int'(THREADS); i++) begin
                state_q[i]   <= state_d[i];
                paddr_q[i]   <= paddr_d[i];
                waiters_q[i] <= waiters_d[i];
            end
            wake_q     <= wake_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // A thread never has two misses outstanding; responses only for issued entries
    assign alloc_conflict = ifd_cache_miss && !any_hit && (state_q[tid] != IMQ_EMPTY);
    assign merge_conflict = ifd_cache_miss && any_hit && waiter_union[tid];
    assign resp_conflict  = l2_response_valid && (state_q[l2_response_idx] != IMQ_WAIT_RESP);

    a_alloc_empty: assert property (@(posedge clk) disable iff (!reset) !alloc_conflict);
    a_merge_fresh: assert property (@(posedge clk) disable iff (!reset) !merge_conflict);
    a_resp_issued: assert property (@(posedge clk) disable iff (!reset) !resp_conflict);

endmodule

// File: tb/tb_ifetch_miss_queue.sv
// Bench for ifetch_miss_queue: directed scenarios plus random traffic against a reference model.
module tb_ifetch_miss_queue;
    import ifetch_miss_queue_pkg::*;

    localparam int T  = THREADS_PER_CORE;
    localparam int IW = $clog2(THREADS_PER_CORE);

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              ifd_cache_miss = 1'b0;
    cache_line_index_t ifd_cache_miss_paddr = '0;
    local_thread_idx_t ifd_cache_miss_thread_idx = '0;
    logic              imq_request_valid;
    cache_line_index_t imq_request_paddr;
    logic [IW-1:0]     imq_request_idx;
    logic              imq_request_ack = 1'b0;
    logic              l2_response_valid = 1'b0;
    logic [IW-1:0]     l2_response_idx = '0;
    logic [T-1:0]      imq_wake_bitmap;

    always #5 clk = ~clk;

    ifetch_miss_queue #(.THREADS(T)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .ifd_cache_miss            (ifd_cache_miss),
        .ifd_cache_miss_paddr      (ifd_cache_miss_paddr),
        .ifd_cache_miss_thread_idx (ifd_cache_miss_thread_idx),
        .imq_request_valid         (imq_request_valid),
        .imq_request_paddr         (imq_request_paddr),
        .imq_request_idx           (imq_request_idx),
        .imq_request_ack           (imq_request_ack),
        .l2_response_valid         (l2_response_valid),
        .l2_response_idx           (l2_response_idx),
        .imq_wake_bitmap           (imq_wake_bitmap)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 = free, 1 = waiting to issue, 2 = waiting for fill
    int          m_state [T];
    int unsigned m_paddr [T];
    int unsigned m_wait  [T];
    int          m_ptr;
    int          m_held;   // entry presented last cycle without ack, -1 if none
    int unsigned m_wake;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < T; i++) begin
            m_state[i] = 0; m_paddr[i] = 0; m_wait[i] = 0;
        end
        m_ptr = 0; m_held = -1; m_wake = 0;
    endtask

    // Entry currently offered to L2, -1 if none
    function automatic int model_grant();
        if (m_held >= 0) return m_held;
        for (int k = 0; k < T; k++) begin
            int i;
            i = (m_ptr + k) % T;
            if (m_state[i] == 1) return i;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        int g;
        g = model_grant();
        check_eq("req_valid", 32'(imq_request_valid), (g >= 0) ? 32'd1 : 32'd0);
        check_eq("req_idx",   32'(imq_request_idx),   (g >= 0) ? 32'(g) : 32'd0);
        check_eq("req_paddr", 32'(imq_request_paddr), (g >= 0) ? m_paddr[g] : 32'd0);
        check_eq("wake",      32'(imq_wake_bitmap),   m_wake);
    endtask

    // One cycle: check current outputs, drive inputs, advance model, clock
    task automatic step(input bit miss, input int tid, input int unsigned paddr,
                        input bit ack, input bit resp, input int ridx);
        int g, h;
        check_outputs();
        ifd_cache_miss            = miss;
        ifd_cache_miss_thread_idx = local_thread_idx_t'(tid);
        ifd_cache_miss_paddr      = cache_line_index_t'(paddr);
        imq_request_ack           = ack;
        l2_response_valid         = resp;
        l2_response_idx           = IW'(ridx);
        g = model_grant();
        h = -1;
        if (miss) begin
            for (int i = 0; i < T; i++)
                if (h < 0 && m_state[i] != 0 && !(resp && ridx == i) && m_paddr[i] == paddr) h = i;
        end
        m_wake = resp ? m_wait[ridx] : 0;
        m_held = (g >= 0 && !ack) ? g : -1;
        if (g >= 0 && ack) begin
            m_state[g] = 2;
            m_ptr = (g + 1) % T;
        end
        if (resp) begin
            m_state[ridx] = 0; m_wait[ridx] = 0;
        end
        if (miss) begin
            if (h >= 0) m_wait[h] = m_wait[h] | (32'd1 << tid);
            else begin
                m_state[tid] = 1; m_wait[tid] = 32'd1 << tid; m_paddr[tid] = paddr;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset in mid-cycle; all outputs must clear immediately
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        ifd_cache_miss = 1'b0; imq_request_ack = 1'b0; l2_response_valid = 1'b0;
        #2;
        check_eq("rst_valid", 32'(imq_request_valid), 32'd0);
        check_eq("rst_paddr", 32'(imq_request_paddr), 32'd0);
        check_eq("rst_idx",   32'(imq_request_idx),   32'd0);
        check_eq("rst_wake",  32'(imq_wake_bitmap),   32'd0);
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int waiting, tid, ridx, nresp;
        bit miss, resp;
        int resp_list [T];
        int elig [T];
        int nelig;

        model_clear();
        do_reset();

        // Single miss
        step(1, 0, 32'h1000, 0, 0, 0);
        check_eq("single_req", {imq_request_valid, 31'(imq_request_paddr)}, {1'b1, 31'h1000});
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        check_eq("single_wake", 32'(imq_wake_bitmap), 32'b0001);
        idle();

        // Merge of T1 and T3 on one line
        step(1, 1, 32'h2000, 0, 0, 0);
        step(1, 3, 32'h2000, 0, 0, 0);
        check_eq("merge_idx", 32'(imq_request_idx), 32'd1);
        step(0, 0, 0, 1, 0, 0);
        check_eq("merge_one_req", 32'(imq_request_valid), 32'd0);
        step(0, 0, 0, 0, 1, 1);
        check_eq("merge_wake", 32'(imq_wake_bitmap), 32'b1010);
        idle();

        // Arbitration order with held ack
        do_reset();
        step(1, 0, 32'h5000, 0, 0, 0);
        step(1, 1, 32'h6000, 0, 0, 0);
        step(1, 2, 32'h7000, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            check_eq("arb_hold_idx", 32'(imq_request_idx), 32'd0);
            idle();
        end
        step(0, 0, 0, 1, 0, 0);
        check_eq("arb_second", 32'(imq_request_idx), 32'd1);
        step(0, 0, 0, 1, 0, 0);
        check_eq("arb_third", 32'(imq_request_idx), 32'd2);
        step(0, 0, 0, 0, 1, 0);
        check_eq("arb_wake0", 32'(imq_wake_bitmap), 32'b0001);
        step(1, 0, 32'h9000, 0, 0, 0);
        step(1, 3, 32'hA000, 1, 0, 0);
        check_eq("arb_next_round", 32'(imq_request_idx), 32'd3);

        // Response and same-line miss in the same cycle
        do_reset();
        step(1, 2, 32'h3000, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(1, 0, 32'h3000, 0, 1, 2);
        check_eq("coll_wake", 32'(imq_wake_bitmap), 32'b0100);
        check_eq("coll_req", {imq_request_valid, 31'(imq_request_paddr)}, {1'b1, 31'h3000});
        check_eq("coll_idx", 32'(imq_request_idx), 32'd0);

        // Miss merging into the entry acked this cycle
        do_reset();
        step(1, 1, 32'h4000, 0, 0, 0);
        step(1, 2, 32'h4000, 1, 0, 0);
        check_eq("ackmerge_noreq", 32'(imq_request_valid), 32'd0);
        step(0, 0, 0, 0, 1, 1);
        check_eq("ackmerge_wake", 32'(imq_wake_bitmap), 32'b0110);
        idle();

        // Reset with two fills outstanding
        step(1, 0, 32'h1000, 0, 0, 0);
        step(1, 1, 32'h2000, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        do_reset();
        for (int c = 0; c < 3; c++) idle();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if (c % 1000 == 999) do_reset();
            nelig = 0;
            for (int t = 0; t < T; t++) begin
                waiting = 0;
                for (int i = 0; i < T; i++) if (m_wait[i][t]) waiting = 1;
                if (!waiting) begin elig[nelig] = t; nelig++; end
            end
            nresp = 0;
            for (int i = 0; i < T; i++) if (m_state[i] == 2) begin resp_list[nresp] = i; nresp++; end
            miss = (nelig > 0) && ($urandom_range(0, 2) == 0);
            tid  = (nelig > 0) ? elig[$urandom_range(0, nelig - 1)] : 0;
            resp = (nresp > 0) && ($urandom_range(0, 2) == 0);
            ridx = (nresp > 0) ? resp_list[$urandom_range(0, nresp - 1)] : 0;
            step(miss, tid, 32'h1000 * $urandom_range(1, 4), 1'($urandom_range(0, 1)), resp, ridx);
        end
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
